// File: rtl/arbitro_escrita_banco_if.sv
// Write-port bundle between the two writeback requesters (ULA, MEM) and the
// register-file write arbiter; master = requester side, slave = arbiter side.
interface arbitro_escrita_banco_if #(
  parameter int LARGURA_DADO = 32,
  parameter int LARGURA_END  = 5,
  parameter int LARGURA_CONT = 16
);
  logic                    req_ula;
  logic [LARGURA_END-1:0]  end_ula;
  logic [LARGURA_DADO-1:0] dado_ula;
  logic                    ack_ula;
  logic                    req_mem;
  logic [LARGURA_END-1:0]  end_mem;
  logic [LARGURA_DADO-1:0] dado_mem;
  logic                    ack_mem;
  logic                    uc_escrita;
  logic [LARGURA_END-1:0]  endereco_escrita;
  logic [LARGURA_DADO-1:0] dado_p_escrita;
  logic                    conflito;
  logic [LARGURA_CONT-1:0] total_escritas;

  modport master (
    output req_ula, end_ula, dado_ula, req_mem, end_mem, dado_mem,
    input  ack_ula, ack_mem, uc_escrita, endereco_escrita, dado_p_escrita,
           conflito, total_escritas
  );

  modport slave (
    input  req_ula, end_ula, dado_ula, req_mem, end_mem, dado_mem,
    output ack_ula, ack_mem, uc_escrita, endereco_escrita, dado_p_escrita,
           conflito, total_escritas
  );
endinterface

// File: rtl/arbitro_escrita_banco.sv
// Round-robin arbiter sharing the register file's single write port between
// ULA and MEM writeback; absorbs r0 writes, counts commits, flags collisions.
module arbitro_escrita_banco #(
  parameter int LARGURA_DADO = 32,
  parameter int LARGURA_END  = 5,
  parameter int LARGURA_CONT = 16
) (
  input logic                   clk,
  input logic                   rst,
  arbitro_escrita_banco_if.slave bus
);

  typedef enum logic {
    PTR_ULA = 1'b0,
    PTR_MEM = 1'b1
  } ptr_t;

  ptr_t                    ptr, ptr_next;
  logic                    ack_ula_q, ack_ula_next;
  logic                    ack_mem_q, ack_mem_next;
  logic                    we_q, we_next;
  logic                    conflito_q, conflito_next;
  logic [LARGURA_END-1:0]  end_q, end_next;
  logic [LARGURA_DADO-1:0] dado_q, dado_next;
  logic [LARGURA_CONT-1:0] cont_q, cont_next;
  logic                    elig_ula, elig_mem, grant_ula, grant_mem;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    ptr_next      = ptr;
    ack_ula_next  = 1'b0;
    ack_mem_next  = 1'b0;
    we_next       = 1'b0;
    end_next      = end_q;
    dado_next     = dado_q;
    cont_next     = cont_q;

    // The visible ack masks the stale request still held during the ack cycle.
    elig_ula  = bus.req_ula & ~ack_ula_q;
    elig_mem  = bus.req_mem & ~ack_mem_q;
    grant_ula = elig_ula & (~elig_mem | (ptr == PTR_ULA));
    grant_mem = elig_mem & ~grant_ula;

    conflito_next = elig_ula & elig_mem & (bus.end_ula == bus.end_mem) &
                    (bus.end_ula != '0);

    if (grant_ula) begin
      ack_ula_next = 1'b1;
      end_next     = bus.end_ula;
      dado_next    = bus.dado_ula;
      ptr_next     = PTR_MEM;
    end else if (grant_mem) begin
      ack_mem_next = 1'b1;
      end_next     = bus.end_mem;
      dado_next    = bus.dado_mem;
      ptr_next     = PTR_ULA;
    end

    if (grant_ula || grant_mem) begin
      we_next = (end_next != '0);
    end

    if (we_next) begin
      cont_next = cont_q + LARGURA_CONT'(1);
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= PTR_ULA;
      ack_ula_q  <= 1'b0;
      ack_mem_q  <= 1'b0;
      we_q       <= 1'b0;
      conflito_q <= 1'b0;
      end_q      <= '0;
      dado_q     <= '0;
      cont_q     <= '0;
    end else begin
      ptr        <= ptr_next;
      ack_ula_q  <= ack_ula_next;
      ack_mem_q  <= ack_mem_next;
      we_q       <= we_next;
      conflito_q <= conflito_next;
      end_q      <= end_next;
      dado_q     <= dado_next;
      cont_q     <= cont_next;
    end
  end

  assign bus.ack_ula          = ack_ula_q;
  assign bus.ack_mem          = ack_mem_q;
  assign bus.uc_escrita       = we_q;
  assign bus.endereco_escrita = end_q;
  assign bus.dado_p_escrita   = dado_q;
  assign bus.conflito         = conflito_q;
  assign bus.total_escritas   = cont_q;

endmodule

// File: tb/tb_arbitro_escrita_banco.sv
// Bench for arbitro_escrita_banco: transaction-level model checked every cycle,
// plus directed scenarios with literal expectations on a modelled register file.
module tb_arbitro_escrita_banco;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   started = 1'b0;
  int   total = 0;
  int   bad = 0;

  arbitro_escrita_banco_if bus ();
  arbitro_escrita_banco_if #(.LARGURA_CONT(4)) bus2 ();

  arbitro_escrita_banco dut (.clk(clk), .rst(rst), .bus(bus.slave));
  arbitro_escrita_banco #(.LARGURA_CONT(4)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  // The narrow-counter instance sees exactly the same requests.
  assign bus2.req_ula  = bus.req_ula;
  assign bus2.end_ula  = bus.end_ula;
  assign bus2.dado_ula = bus.dado_ula;
  assign bus2.req_mem  = bus.req_mem;
  assign bus2.end_mem  = bus.end_mem;
  assign bus2.dado_mem = bus.dado_mem;

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Register file fed by the arbiter's write port.
  logic [31:0] banco [32];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) banco[i] <= '0;
    end else if (bus.uc_escrita && bus.endereco_escrita != 5'd0) begin
      banco[bus.endereco_escrita] <= bus.dado_p_escrita;
    end
  end

  // Transaction-level model: who is served, what lands, how many commits.
  bit          m_ack_ula, m_ack_mem, m_we, m_conf;
  logic [4:0]  m_end;
  logic [31:0] m_dado;
  int          m_total;
  int          m_last;   // 0 none since reset, 1 ULA, 2 MEM
  bit          eu, em, wu, wm;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ack_ula = 0; m_ack_mem = 0; m_we = 0; m_conf = 0;
      m_end = '0; m_dado = '0; m_total = 0; m_last = 0;
    end else begin
      eu = bus.req_ula && !m_ack_ula;
      em = bus.req_mem && !m_ack_mem;
      wu = eu && (!em || m_last != 1);
      wm = em && !wu;
      m_conf = eu && em && (bus.end_ula == bus.end_mem) && (bus.end_ula != 5'd0);
      m_ack_ula = wu;
      m_ack_mem = wm;
      m_we = 0;
      if (wu || wm) begin
        m_end  = wu ? bus.end_ula : bus.end_mem;
        m_dado = wu ? bus.dado_ula : bus.dado_mem;
        m_we   = (m_end != 5'd0);
        if (m_we) m_total++;
        m_last = wu ? 1 : 2;
      end
    end
  end

  always @(negedge clk) begin
    if (started && !rst) begin
      check("ack_ula", bus.ack_ula, m_ack_ula);
      check("ack_mem", bus.ack_mem, m_ack_mem);
      check("uc_escrita", bus.uc_escrita, m_we);
      check("endereco", bus.endereco_escrita, m_end);
      check("dado", bus.dado_p_escrita, m_dado);
      check("conflito", bus.conflito, m_conf);
      check("total16", bus.total_escritas, m_total % 65536);
      check("total4", bus2.total_escritas, m_total % 16);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_ula = 0; bus.end_ula = '0; bus.dado_ula = '0;
    bus.req_mem = 0; bus.end_mem = '0; bus.dado_mem = '0;
  endtask

  task automatic do_reset();
    rst = 1;
    clear_inputs();
    step();
    step();
    rst = 0;
  endtask

  task automatic write_ula(input logic [4:0] a, input logic [31:0] d);
    int n;
    bus.req_ula = 1; bus.end_ula = a; bus.dado_ula = d;
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.ack_ula && n < 8);
    check("ula_handshake", bus.ack_ula, 1);
    step();
    bus.req_ula = 0;
  endtask

  initial begin
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack_ula", bus.ack_ula, 0);
    check("rst_uc", bus.uc_escrita, 0);
    check("rst_total", bus.total_escritas, 0);
    rst = 0;
    started = 1;

    // Single ULA write
    bus.req_ula = 1; bus.end_ula = 5'd2; bus.dado_ula = 32'd10;
    step();
    check("single_ack", bus.ack_ula, 1);
    check("single_uc", bus.uc_escrita, 1);
    check("single_end", bus.endereco_escrita, 2);
    check("single_dado", bus.dado_p_escrita, 10);
    step();
    bus.req_ula = 0;
    step();
    check("single_r2", banco[2], 10);
    check("single_total", bus.total_escritas, 1);

    // Asynchronous reset mid-cycle while a request is held
    do_reset();
    bus.req_ula = 1; bus.end_ula = 5'd5; bus.dado_ula = 32'h1234;
    step();
    #1 rst = 1;
    #1;
    check("arst_ack_ula", bus.ack_ula, 0);
    check("arst_uc", bus.uc_escrita, 0);
    check("arst_end", bus.endereco_escrita, 0);
    check("arst_dado", bus.dado_p_escrita, 0);
    check("arst_total", bus.total_escritas, 0);
    check("arst_conflito", bus.conflito, 0);
    #4 rst = 0;
    @(posedge clk);
    #1;
    check("ack_after_rst", bus.ack_ula, 1);
    step();
    bus.req_ula = 0;
    step();

    // r0 write absorbed; pointer then favours ULA again under contention
    do_reset();
    write_ula(5'd1, 32'h11);
    bus.req_mem = 1; bus.end_mem = 5'd0; bus.dado_mem = 32'hFFFF;
    step();
    check("r0_ack_mem", bus.ack_mem, 1);
    check("r0_uc", bus.uc_escrita, 0);
    step();
    bus.req_mem = 0;
    step();
    check("r0_banco", banco[0], 0);
    check("r0_total", bus.total_escritas, 1);

    bus.req_ula = 1; bus.end_ula = 5'd3; bus.dado_ula = 32'hAAAA;
    bus.req_mem = 1; bus.end_mem = 5'd4; bus.dado_mem = 32'h5555;
    step();
    check("cont_first_ula", bus.ack_ula, 1);
    check("cont_first_mem", bus.ack_mem, 0);
    step();
    bus.req_ula = 0;
    check("cont_second_mem", bus.ack_mem, 1);
    check("cont_second_ula", bus.ack_ula, 0);
    step();
    bus.req_mem = 0;
    step();
    check("cont_r3", banco[3], 32'hAAAA);
    check("cont_r4", banco[4], 32'h5555);
    check("cont_total", bus.total_escritas, 3);

    // Same-address collision
    do_reset();
    bus.req_ula = 1; bus.end_ula = 5'd7; bus.dado_ula = 32'd1;
    bus.req_mem = 1; bus.end_mem = 5'd7; bus.dado_mem = 32'd2;
    step();
    check("col_conflito", bus.conflito, 1);
    check("col_ack_ula", bus.ack_ula, 1);
    step();
    bus.req_ula = 0;
    check("col_conflito_end", bus.conflito, 0);
    check("col_ack_mem", bus.ack_mem, 1);
    step();
    bus.req_mem = 0;
    step();
    check("col_r7", banco[7], 2);

    // Counter wrap on the 4-bit instance
    do_reset();
    for (int i = 0; i < 17; i++) begin
      write_ula(5'((i % 31) + 1), 32'(i));
    end
    step();
    check("wrap_total4", bus2.total_escritas, 1);
    check("wrap_total16", bus.total_escritas, 17);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arbitro_escrita_banco.md
Name: arbitro_escrita_banco

Overview:
- Two-requester write-port arbiter for the 32x32 register file (banco). Its outputs drive the register file's single write port.
- It shares that port between the ALU writeback path (ULA) and the memory/load writeback path (MEM) using round-robin priority and a req/ack handshake.
- Writes to register 0 are absorbed: they are acknowledged but never reach the register file.
- It also counts committed writes and flags same-address collisions.

Parameters:
- LARGURA_DADO, 32, data width of the write port.
- LARGURA_END, 5, register address width.
- LARGURA_CONT, 16, width of the committed-write counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_ula  input  1  ULA write request; held high until ack_ula is seen.
- end_ula  input  LARGURA_END  ULA destination register; stable while req_ula is high.
- dado_ula  input  LARGURA_DADO  ULA write data; stable while req_ula is high.
- ack_ula  output  1  one-cycle grant pulse to ULA.
- req_mem  input  1  MEM write request; same rules as req_ula.
- end_mem  input  LARGURA_END  MEM destination register.
- dado_mem  input  LARGURA_DADO  MEM write data.
- ack_mem  output  1  one-cycle grant pulse to MEM.
- uc_escrita  output  1  write enable to the register file.
- endereco_escrita  output  LARGURA_END  write address to the register file.
- dado_p_escrita  output  LARGURA_DADO  write data to the register file.
- conflito  output  1  pulse: both requesters eligible with the same nonzero address.
- total_escritas  output  LARGURA_CONT  count of writes issued with uc_escrita=1.

Behaviour:
- Reset (asynchronous, any time):
  - ack_ula, ack_mem, uc_escrita and conflito go to 0.
  - endereco_escrita, dado_p_escrita and total_escritas go to 0.
  - Priority pointer is set to ULA.
  - Requests in flight are dropped. A requester still holding req after rst falls is granted normally; there is no lost-ack recovery beyond this.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Eligibility in cycle N:
  - elig_ula = req_ula & ~ack_ula.
  - elig_mem = req_mem & ~ack_mem.
  - The ack mask blocks a re-grant on the stale req in the cycle the ack is visible.
- Grant decision at the rising edge ending cycle N:
  - Only ULA eligible: grant ULA.
  - Only MEM eligible: grant MEM.
  - Both eligible: grant the requester named by the pointer.
  - Neither eligible: no grant; uc_escrita=0 next cycle and address/data hold their last values.
- Grant effects, all visible in cycle N+1:
  - ack of the winner = 1; the other ack = 0.
  - endereco_escrita and dado_p_escrita take the winner's address and data.
  - uc_escrita = 1 only if the winner's address is not 0.
  - The register file commits at the rising edge ending N+1.
  - Latency is 1 cycle from request sample to the write-enable cycle.
- Pointer: after any grant, including a grant to address 0, the pointer moves to the non-winner. It is unchanged when there is no grant.
- Requester rule: deassert req, or present a new transaction, in the cycle after seeing ack.
  - Maximum throughput is 1 write/cycle overall and 1 write per 2 cycles per requester.
  - Under contention the two requesters alternate ULA, MEM, ULA, ...
- conflito:
  - Registered. It is 1 in N+1 when both are eligible in N with end_ula == end_mem != 0; otherwise 0.
  - Grant order is not changed by a collision. The loser's write lands later and prevails, and upstream logic owns ordering.
- total_escritas: increments by 1 at each edge where uc_escrita=1 is issued, wraps modulo 2^LARGURA_CONT, and does not count address-0 grants.
- Simultaneous reset and request: reset wins; no ack is issued in that cycle.

Test Plan:
- Reset: rst=1 mid-cycle with req_ula=1 -> all outputs 0 immediately (asynchronous), pointer at ULA. After release, ack_ula=1 one cycle later.
- Single ULA write: req_ula=1, end_ula=2, dado_ula=10 -> next cycle ack_ula=1, uc_escrita=1, endereco_escrita=2, dado_p_escrita=10. Then read port address 2 returns 10 and total_escritas=1.
- Contention: req_ula (r3=0xAAAA) and req_mem (r4=0x5555) both held -> grants alternate ULA, then MEM on consecutive cycles. The register file ends with r3=0xAAAA, r4=0x5555 and total_escritas=2.
- Register 0: req_mem=1, end_mem=0, dado_mem=0xFFFF -> ack_mem=1 with uc_escrita=0. Read of address 0 stays 0, total_escritas is unchanged, and the pointer moves to ULA.
- Collision: both request r7 (ULA=1, MEM=2) with pointer=ULA -> conflito=1 for one cycle. Writes occur as ULA then MEM, so r7 ends at 2.
- Wrap: LARGURA_CONT=4 with 17 single ULA writes -> total_escritas=1.
